// File: rtl/shared_mem_arbiter_pkg.sv
// Shared types and default sizing for the shared matrix/vector memory front end.
package shared_mem_arbiter_pkg;

  localparam int SHM_NUM_UNITS = 32;
  localparam int SHM_DEPTH     = 64;
  localparam int SHM_DATA_W    = 256;
  localparam int SHM_ADDR_W    = $clog2(SHM_DEPTH);

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } shm_state_e;

  typedef logic [SHM_ADDR_W-1:0] shm_addr_t;

endpackage

// File: rtl/shared_mem_arbiter_rr.sv
// Combinational round-robin picker: first set req bit at or after ptr, wrapping at N.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  int   idx;
  logic found;

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int i = 0; i < N; i++) begin
      idx = int'(ptr) + i;
      if (idx >= N) idx = idx - N;
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/shared_mem_arbiter.sv
// N-unit round-robin front end with locked bursts for one single-port shared memory.
// Optional SHMEM_STATS_EN adds saturating grant/stall counters.
module shared_mem_arbiter
  import shared_mem_arbiter_pkg::*;
#(
  parameter  int NUM_UNITS = SHM_NUM_UNITS,
  parameter  int DATA_W    = SHM_DATA_W,
  parameter  int DEPTH     = SHM_DEPTH,
  localparam int ADDR_W    = $clog2(DEPTH),
  localparam int IW        = $clog2(NUM_UNITS)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_UNITS-1:0]          req_valid,
  input  logic [NUM_UNITS-1:0]          req_we,
  input  logic [NUM_UNITS-1:0]          req_last,
  input  logic [NUM_UNITS*ADDR_W-1:0]   req_addr,
  input  logic [NUM_UNITS*DATA_W-1:0]   req_wdata,
  output logic [NUM_UNITS-1:0]          req_ready,
  output logic [NUM_UNITS-1:0]          rsp_valid,
  output logic [DATA_W-1:0]             rsp_rdata,
`ifdef SHMEM_STATS_EN
  output logic [31:0]                   stat_grants,
  output logic [31:0]                   stat_stalls,
`endif
  output logic                          busy
);

  shm_state_e           state;
  logic [IW-1:0]        ptr;
  logic [IW-1:0]        lock_id;
  logic [NUM_UNITS-1:0] arb_gnt;
  logic [IW-1:0]        arb_idx;

  logic [IW-1:0]        win_idx;
  logic                 accept;
  logic                 acc_we;
  logic                 acc_last;
  logic [ADDR_W-1:0]    acc_addr;
  logic [DATA_W-1:0]    acc_wdata;
  logic                 in_range;
  logic [IW-1:0]        next_ptr;

  logic [DATA_W-1:0]    mem [DEPTH];

  rr_arbiter #(.N(NUM_UNITS)) u_rr (
    .req     (req_valid),
    .ptr     (ptr),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx)
  );

  // Grant is combinational so a beat is accepted in the same cycle it wins.
  always_comb begin
    req_ready = '0;
    win_idx   = arb_idx;
    if (!rst) begin
      if (state == IDLE) begin
        req_ready = arb_gnt;
      end else begin
        win_idx            = lock_id;
        req_ready[lock_id] = req_valid[lock_id];
      end
    end
  end

  assign accept    = |req_ready;
  assign acc_we    = req_we[win_idx];
  assign acc_last  = req_last[win_idx];
  assign acc_addr  = req_addr[win_idx*ADDR_W +: ADDR_W];
  assign acc_wdata = req_wdata[win_idx*DATA_W +: DATA_W];
  assign next_ptr  = (win_idx == IW'(NUM_UNITS - 1)) ? '0 : win_idx + 1'b1;

  // Only a non-power-of-2 depth leaves encodable addresses without backing words.
  generate
    if (DEPTH == (1 << ADDR_W)) begin : g_full_range
      assign in_range = 1'b1;
    end else begin : g_part_range
      assign in_range = ({1'b0, acc_addr} < (ADDR_W + 1)'(DEPTH));
    end
  endgenerate

  // NOTE: the memory array has no reset branch; clearing DEPTH words would stop it mapping onto a RAM macro.
  always_ff @(posedge clk) begin
    if (accept && acc_we && in_range) mem[acc_addr] <= acc_wdata;
  end

  // NOTE: clocked state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      lock_id   <= '0;
      busy      <= 1'b0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= '0;
      if (accept && !acc_we) begin
        rsp_valid <= req_ready;
        rsp_rdata <= in_range ? mem[acc_addr] : '0;
      end
      case (state)
        IDLE: begin
          if (accept) begin
            if (!acc_last) begin
              state   <= LOCK;
              lock_id <= win_idx;
              busy    <= 1'b1;
            end else begin
              ptr <= next_ptr;
            end
          end
        end
        LOCK: begin
          // Gaps (valid low) simply hold the lock until the last beat arrives.
          if (accept && acc_last) begin
            state <= IDLE;
            busy  <= 1'b0;
            ptr   <= next_ptr;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SHMEM_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_grants <= '0;
      stat_stalls <= '0;
    end else begin
      if (accept && (stat_grants != '1)) stat_grants <= stat_grants + 32'd1;
      if ((|(req_valid & ~req_ready)) && (stat_stalls != '1)) stat_stalls <= stat_stalls + 32'd1;
    end
  end
`endif

endmodule
